multicycle_sequencer: RTL and testbench

- Multi-cycle instruction sequencer for the 4-bit-opcode core.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and generates per-phase strobes for the PC, IR, ALU, data memory and register file.
- Handles the instruction-memory and data-memory req/ack handshakes, with a timeout.
- Sits between the instruction/data memory interfaces and the datapath, alongside the opcode control decoder.

---
 rtl/multicycle_sequencer_pkg.sv | 41 ++++
 rtl/multicycle_sequencer_op_class.sv | 22 ++
 rtl/multicycle_sequencer.sv | 107 ++++++++++
 tb/tb_multicycle_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_sequencer_pkg.sv
// seq_pkg: shared state, opcode, PC-source and opcode-class definitions for the multicycle sequencer.
// No ports; imported by seq_op_class and multicycle_sequencer.
package seq_pkg;

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_e;

    // Flat state constants used by the FSM register (encodings follow state_e)
    localparam logic [2:0] ST_IDLE   = 3'(IDLE);
    localparam logic [2:0] ST_FETCH  = 3'(FETCH);
    localparam logic [2:0] ST_DECODE = 3'(DECODE);
    localparam logic [2:0] ST_EXEC   = 3'(EXEC);
    localparam logic [2:0] ST_MEM    = 3'(MEM);
    localparam logic [2:0] ST_WB     = 3'(WB);
    localparam logic [2:0] ST_HALT   = 3'(HALT);

    localparam logic [3:0] OP_HALT = 4'b0000;
    localparam logic [3:0] OP_JMP  = 4'b0001;
    localparam logic [3:0] OP_BEQ  = 4'b0100;
    localparam logic [3:0] OP_BNE  = 4'b0101;
    localparam logic [3:0] OP_BLT  = 4'b0110;
    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b1001;
    localparam logic [3:0] OP_LW   = 4'b1010;
    localparam logic [3:0] OP_SW   = 4'b1011;
    localparam logic [3:0] OP_LB   = 4'b1100;
    localparam logic [3:0] OP_SB   = 4'b1101;
    localparam logic [3:0] OP_MOV  = 4'b1111;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

    typedef enum logic [2:0] {
        CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP, CLS_HALT, CLS_ILLEGAL
    } op_class_e;

    function automatic logic is_mem_class(op_class_e c);
        return c == CLS_LOAD || c == CLS_STORE;
    endfunction

endpackage

// File: rtl/multicycle_sequencer_op_class.sv
// seq_op_class: combinational classification of a 4-bit opcode.
// Ports: opcode (in, 4) opcode to classify; op_class (out, op_class_e) its class.
module seq_op_class
    import seq_pkg::*;
(
    input  logic [3:0] opcode,
    output op_class_e  op_class
);

    always_comb begin
        case (opcode)
            OP_ADD, OP_SUB, OP_MOV: op_class = CLS_ALU;
            OP_LW, OP_LB:           op_class = CLS_LOAD;
            OP_SW, OP_SB:           op_class = CLS_STORE;
            OP_BEQ, OP_BNE, OP_BLT: op_class = CLS_BRANCH;
            OP_JMP:                 op_class = CLS_JUMP;
            OP_HALT:                op_class = CLS_HALT;
            default:                op_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: FETCH/DECODE/EXEC/MEM/WB sequencer with memory handshakes and request timeout.
// Ports: clk, reset (async, active-low), start, opcode[3:0], imem_ack, dmem_ack, branch_taken in;
//        imem_req, ir_write, alu_en, dmem_req, dmem_we, reg_write, mem_to_reg, pc_write,
//        pc_src[1:0], retire, illegal_op, bus_err (sticky), halted, instr_count[31:0] out.
// Build option: define SEQ_PERF_CNT_EN to count retired instructions on instr_count (else tied to 0).
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  opcode,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    input  logic        branch_taken,
    output logic        imem_req,
    output logic        ir_write,
    output logic        alu_en,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        retire,
    output logic        illegal_op,
    output logic        bus_err,
    output logic        halted,
    output logic [31:0] instr_count
);

    logic [2:0]       state, state_nx;
    logic [3:0]       op_q;
    logic [CNT_W-1:0] cnt;
    op_class_e        dec_cls, cur_cls;
    logic             waiting, timeout;

    seq_op_class u_dec_cls (.opcode(opcode), .op_class(dec_cls));
    seq_op_class u_cur_cls (.opcode(op_q),   .op_class(cur_cls));

    assign waiting = (state == ST_FETCH && !imem_ack) || (state == ST_MEM && !dmem_ack);
    // Fires in the last allowed wait cycle; an ack in that same cycle keeps waiting low and wins.
    assign timeout = waiting && (TIMEOUT_CYCLES != 0) && (int'(cnt) == TIMEOUT_CYCLES - 1);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   state_nx = start ? ST_FETCH : ST_IDLE;
            ST_FETCH:  state_nx = imem_ack ? ST_DECODE : timeout ? ST_HALT : ST_FETCH;
            ST_DECODE: state_nx = dec_cls == CLS_HALT ? ST_HALT :
                                  dec_cls == CLS_ILLEGAL ? ST_FETCH : ST_EXEC;
            ST_EXEC:   state_nx = (cur_cls == CLS_BRANCH || cur_cls == CLS_JUMP) ? ST_FETCH :
                                  is_mem_class(cur_cls) ? ST_MEM : ST_WB;
            ST_MEM:    state_nx = dmem_ack ? (cur_cls == CLS_LOAD ? ST_WB : ST_FETCH) :
                                  timeout ? ST_HALT : ST_MEM;
            ST_WB:     state_nx = ST_FETCH;
            ST_HALT:   state_nx = start ? ST_FETCH : ST_HALT;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Ack-qualified strobes follow the ack combinationally so a transfer completes in its ack cycle.
    always_comb begin
        imem_req   = state == ST_FETCH;
        ir_write   = imem_req && imem_ack;
        alu_en     = state == ST_EXEC;
        dmem_req   = state == ST_MEM;
        dmem_we    = dmem_req && cur_cls == CLS_STORE;
        reg_write  = state == ST_WB;
        mem_to_reg = reg_write && cur_cls == CLS_LOAD;
        illegal_op = state == ST_DECODE && dec_cls == CLS_ILLEGAL;
        retire     = (alu_en && (cur_cls == CLS_BRANCH || cur_cls == CLS_JUMP)) ||
                     (dmem_we && dmem_ack) || reg_write;
        pc_write   = retire || illegal_op;
        pc_src     = (alu_en && cur_cls == CLS_JUMP) ? PC_JMP :
                     (alu_en && cur_cls == CLS_BRANCH && branch_taken) ? PC_BR : PC_INC;
        halted     = state == ST_HALT;
    end

    // The wait counter is zero whenever no request is stalling, so it is clear on every FETCH/MEM entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            op_q    <= '0;
            cnt     <= '0;
            bus_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_DECODE) op_q <= opcode;
            cnt <= (waiting && !timeout) ? cnt + CNT_W'(1) : '0;
            if (timeout) bus_err <= 1'b1;
        end
    end

`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) instr_count <= '0;
        else if (retire) instr_count <= instr_count + 32'd1;
    end
`else
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: randomized instruction stream checked against a closed-form timing model.
module tb_multicycle_sequencer;

    localparam int TO = 16;

    logic        clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic        imem_ack = 1'b0, dmem_ack = 1'b0, branch_taken = 1'b0;
    logic [3:0]  opcode = '0;
    logic        imem_req, ir_write, alu_en, dmem_req, dmem_we, reg_write, mem_to_reg;
    logic        pc_write, retire, illegal_op, bus_err, halted;
    logic [1:0]  pc_src;
    logic [31:0] instr_count;
    logic [11:0] strobes;

    int   checks = 0, fails = 0, retired = 0;
    logic exp_bus_err = 1'b0;
    byte  cls_tab [16];

    multicycle_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .branch_taken(branch_taken),
        .imem_req(imem_req), .ir_write(ir_write), .alu_en(alu_en), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .pc_write(pc_write),
        .pc_src(pc_src), .retire(retire), .illegal_op(illegal_op), .bus_err(bus_err),
        .halted(halted), .instr_count(instr_count)
    );

    assign strobes = {imem_req, ir_write, alu_en, dmem_req, dmem_we, reg_write,
                      mem_to_reg, pc_write, pc_src, retire, illegal_op};

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no summary, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt();
`ifdef SEQ_PERF_CNT_EN
        return 32'(retired);
`else
        return 32'd0;
`endif
    endfunction

    // Called one step after the edge that entered FETCH; returns one step after the edge that follows
    // the instruction's terminal cycle (retire, illegal pulse, or first HALT cycle).
    task automatic run_instr(input logic [3:0] op, input int wi, input int wd, input logic bt);
        int k = 0, ireq = 0, dreq = 0, dwe = 0, rw = 0, alu = 0;
        int ek = 0, eireq, edreq = 0, edwe = 0, erw = 0, ealu = 0, base, kind = 0;
        logic [1:0]  epc = 2'b00, spc = 2'b00;
        logic        em2r = 1'b0, eto = 1'b0, done = 1'b0;
        logic        sm2r = 1'b0, spw = 1'b0, sret = 1'b0, sill = 1'b0, shalt = 1'b0;
        logic [11:0] sstr = '0;
        byte         c;
        string       t;
        c = cls_tab[op];
        t = $sformatf("op=%b wi=%0d wd=%0d bt=%0d", op, wi, wd, bt);
        base  = wi + 1;
        eireq = wi >= TO ? TO : wi + 1;
        if (wi >= TO) begin
            kind = 2; ek = TO + 1; eto = 1'b1;
        end else begin
            case (c)
                "H": begin kind = 2; ek = base + 2; end
                "I": begin kind = 1; ek = base + 1; end
                "B", "J": begin ek = base + 2; ealu = 1; epc = c == "J" ? 2'b10 : {1'b0, bt}; end
                "A": begin ek = base + 3; ealu = 1; erw = 1; end
                default: begin
                    ealu = 1;
                    if (wd >= TO) begin
                        kind = 2; ek = base + 2 + TO + 1; eto = 1'b1; edreq = TO;
                        edwe = c == "S" ? TO : 0;
                    end else begin
                        ek = c == "L" ? base + wd + 4 : base + wd + 3;
                        edreq = wd + 1; edwe = c == "S" ? wd + 1 : 0;
                        erw = c == "L" ? 1 : 0; em2r = c == "L";
                    end
                end
            endcase
        end
        opcode = op;
        branch_taken = bt;
        while (k < 60 && !done) begin
            k++;
            start    = halted ? 1'b0 : 1'($urandom_range(0, 1));
            imem_ack = imem_req ? (ireq == wi) : 1'($urandom_range(0, 1));
            dmem_ack = dmem_req ? (dreq == wd) : 1'($urandom_range(0, 1));
            #2;
            ireq += int'(imem_req);
            dreq += int'(dmem_req);
            dwe  += int'(dmem_we);
            rw   += int'(reg_write);
            alu  += int'(alu_en);
            if (retire || illegal_op || halted) begin
                done = 1'b1;
                sstr = strobes; spc = pc_src; sm2r = mem_to_reg; spw = pc_write;
                sret = retire; sill = illegal_op; shalt = halted;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        if (eto) exp_bus_err = 1'b1;
        chk({t, " terminal reached"}, 32'(done), 1);
        chk({t, " latency"}, k, ek);
        chk({t, " imem_req cycles"}, ireq, eireq);
        chk({t, " dmem_req cycles"}, dreq, edreq);
        chk({t, " dmem_we cycles"}, dwe, edwe);
        chk({t, " alu_en cycles"}, alu, ealu);
        chk({t, " reg_write cycles"}, rw, erw);
        if (kind == 2) begin
            chk({t, " halted"}, 32'(shalt), 1);
            chk({t, " halt strobes"}, 32'(sstr), 0);
            chk({t, " bus_err"}, 32'(bus_err), 32'(exp_bus_err));
            #2;
            chk({t, " halt hold"}, {halted, strobes}, {1'b1, 12'h000});
            @(posedge clk);
            #1;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            chk({t, " resume fetch"}, 32'(imem_req), 1);
        end else begin
            if (kind == 0) retired++;
            chk({t, " retire"}, 32'(sret), 32'(kind == 0));
            chk({t, " illegal_op"}, 32'(sill), 32'(kind == 1));
            chk({t, " pc_write"}, 32'(spw), 1);
            chk({t, " pc_src"}, 32'(spc), 32'(epc));
            chk({t, " mem_to_reg"}, 32'(sm2r), 32'(em2r));
            chk({t, " next fetch"}, 32'(imem_req), 1);
            chk({t, " bus_err"}, 32'(bus_err), 32'(exp_bus_err));
        end
        chk({t, " instr_count"}, instr_count, exp_cnt());
    endtask

    function automatic int pick_wait();
        return ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 3));
    endfunction

    initial begin
        cls_tab = '{"H", "J", "I", "I", "B", "B", "B", "I", "A", "A", "L", "S", "L", "S", "I", "A"};
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", {18'd0, strobes, bus_err, halted}, 0);
        chk("reset instr_count", instr_count, 0);
        reset = 1'b1;
        imem_ack = 1'b1; dmem_ack = 1'b1;
        @(posedge clk);
        #1;
        imem_ack = 1'b0; dmem_ack = 1'b0;
        chk("idle ignores acks", {halted, strobes}, 0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("fetch after start", 32'(imem_req), 1);
        run_instr(4'b1111, 0, 0, 1'b0);
        run_instr(4'b1010, 0, 3, 1'b0);
        run_instr(4'b0101, 0, 0, 1'b1);
        run_instr(4'b0101, 1, 0, 1'b0);
        run_instr(4'b0001, 0, 0, 1'b1);
        run_instr(4'b1011, 0, 15, 1'b0);
        run_instr(4'b0111, 0, 0, 1'b0);
        run_instr(4'b0000, 0, 0, 1'b0);
        run_instr(4'b1101, 0, 99, 1'b0);
        run_instr(4'b1100, 15, 2, 1'b0);
        run_instr(4'b1001, 16, 0, 1'b0);
        for (int i = 0; i < 40; i++)
            run_instr(4'($urandom_range(0, 15)), pick_wait(), pick_wait(), 1'($urandom_range(0, 1)));
        #1;
        chk("in fetch before async reset", 32'(imem_req), 1);
        reset = 1'b0;
        #1;
        chk("async reset outputs", {18'd0, strobes, bus_err, halted}, 0);
        chk("async reset instr_count", instr_count, 0);
        retired = 0;
        exp_bus_err = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) run_instr(4'b1000, 0, 0, 1'b0);
        chk("three alu retires counted", instr_count, exp_cnt());
        #1;
        reset = 1'b0;
        #1;
        chk("count cleared by reset", instr_count, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
